// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the halt-and-dump debug controller.
package cpu_dbg_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_DRAIN,
    ST_READ,
    ST_CAPTURE,
    ST_SEND,
    ST_TRAILER,
    ST_FINISH
  } dbg_state_e;

  // The default halt sentinel is an all-ones word of whatever data width is chosen.
  localparam logic DEF_HALT_FILL    = 1'b1;
  localparam int   DEF_DRAIN_CYCLES = 3;
  localparam int   DRAIN_CNT_W      = 8;

endpackage

// File: rtl/dbg_cycle_counter.sv
// Saturating up-counter with synchronous clear, enable and freeze.
module dbg_cycle_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         frz_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, then count up unless frozen or already at max.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && !frz_i && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/halt_dump_ctrl.sv
// Watches the fetch stream for a halt sentinel, drains the pipeline, freezes
// the CPU and streams the data memory out followed by a cycle-count trailer.
module halt_dump_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                ADDR_W       = 9,
  parameter int                DEPTH        = 512,
  parameter logic [DATA_W-1:0] HALT_WORD    = {DATA_W{DEF_HALT_FILL}},
  parameter int                DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int                CNT_W        = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] RD,
  input  logic              RD_VALID,
  output logic              MEM_RE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_DATA,
  output logic              CPU_FREEZE,
  output logic              DUMP_VALID,
  input  logic              DUMP_READY,
  output logic [DATA_W-1:0] DUMP_DATA,
  output logic [ADDR_W-1:0] DUMP_ADDR,
  output logic              DUMP_LAST,
  output logic              DUMP_TRAILER,
  output logic [CNT_W-1:0]  CYCLE_COUNT,
  output logic              HALTED,
  output logic              DONE
);

  localparam logic [ADDR_W-1:0]      LAST_PTR   = ADDR_W'(DEPTH - 1);
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

  dbg_state_e              state_q;
  logic [ADDR_W-1:0]       ptr_q;
  logic                    halted_q, done_q, freeze_q, mem_re_q;
  logic [ADDR_W-1:0]       mem_addr_q, dump_addr_q;
  logic                    dump_valid_q, dump_last_q, dump_trailer_q;
  logic [DATA_W-1:0]       dump_data_q;
  logic [CNT_W-1:0]        cyc_cnt;
  logic [DRAIN_CNT_W-1:0]  drain_cnt;
  logic                    hit;

  assign hit = RD_VALID && (RD == HALT_WORD);

  // Run-length counter: counts every RUN cycle including the detection cycle.
  dbg_cycle_counter #(.W(CNT_W)) u_cyc_cnt (
    .clk_i (CLK),
    .rst_i (RESET),
    .clr_i (1'b0),
    .en_i  (state_q == ST_RUN),
    .frz_i (halted_q),
    .cnt_o (cyc_cnt)
  );

  // Drain timer: zero on DRAIN entry, advances once per DRAIN cycle.
  dbg_cycle_counter #(.W(DRAIN_CNT_W)) u_drain_cnt (
    .clk_i (CLK),
    .rst_i (RESET),
    .clr_i (state_q != ST_DRAIN),
    .en_i  (state_q == ST_DRAIN),
    .frz_i (1'b0),
    .cnt_o (drain_cnt)
  );

  // Control FSM; every output is registered alongside the state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= ST_RUN;
      ptr_q          <= '0;
      halted_q       <= 1'b0;
      done_q         <= 1'b0;
      freeze_q       <= 1'b0;
      mem_re_q       <= 1'b0;
      mem_addr_q     <= '0;
      dump_valid_q   <= 1'b0;
      dump_last_q    <= 1'b0;
      dump_trailer_q <= 1'b0;
      dump_data_q    <= '0;
      dump_addr_q    <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hit) begin
            halted_q <= 1'b1;
            if (DRAIN_CYCLES == 0) begin
              state_q    <= ST_READ;
              ptr_q      <= '0;
              mem_re_q   <= 1'b1;
              mem_addr_q <= '0;
              freeze_q   <= 1'b1;
            end else begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state_q    <= ST_READ;
            ptr_q      <= '0;
            mem_re_q   <= 1'b1;
            mem_addr_q <= '0;
            freeze_q   <= 1'b1;
          end
        end
        ST_READ: begin
          mem_re_q <= 1'b0;
          state_q  <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          dump_data_q  <= MEM_DATA;
          dump_addr_q  <= ptr_q;
          dump_valid_q <= 1'b1;
          state_q      <= ST_SEND;
        end
        ST_SEND: begin
          if (DUMP_READY) begin
            if (ptr_q == LAST_PTR) begin
              // Valid stays high: the trailer beat follows back-to-back.
              dump_trailer_q <= 1'b1;
              dump_last_q    <= 1'b1;
              dump_addr_q    <= '0;
              dump_data_q    <= DATA_W'(cyc_cnt);
              state_q        <= ST_TRAILER;
            end else begin
              dump_valid_q <= 1'b0;
              ptr_q        <= ptr_q + 1'b1;
              mem_re_q     <= 1'b1;
              mem_addr_q   <= ptr_q + 1'b1;
              state_q      <= ST_READ;
            end
          end
        end
        ST_TRAILER: begin
          if (DUMP_READY) begin
            dump_valid_q   <= 1'b0;
            dump_trailer_q <= 1'b0;
            dump_last_q    <= 1'b0;
            done_q         <= 1'b1;
            state_q        <= ST_FINISH;
          end
        end
        ST_FINISH: state_q <= ST_FINISH;
        default:   state_q <= ST_RUN;
      endcase
    end
  end

  assign MEM_RE       = mem_re_q;
  assign MEM_ADDR     = mem_addr_q;
  assign CPU_FREEZE   = freeze_q;
  assign DUMP_VALID   = dump_valid_q;
  assign DUMP_DATA    = dump_data_q;
  assign DUMP_ADDR    = dump_addr_q;
  assign DUMP_LAST    = dump_last_q;
  assign DUMP_TRAILER = dump_trailer_q;
  assign CYCLE_COUNT  = cyc_cnt;
  assign HALTED       = halted_q;
  assign DONE         = done_q;

endmodule

// File: tb/tb_halt_dump_ctrl.sv
// Scoreboard bench: three controller instances (DEPTH=4, DEPTH=512 with
// random backpressure and a mid-dump reset, CNT_W=4 with no drain).
module tb_halt_dump_ctrl;

  localparam logic [31:0] HW = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [8:0]  addr;
    logic [31:0] data;
    logic        last;
    logic        trl;
  } beat_t;

  function automatic int dep_of(int g);
    return (g == 0) ? 4 : (g == 1) ? 512 : 2;
  endfunction

  function automatic int drn_of(int g);
    return (g == 2) ? 0 : 3;
  endfunction

  function automatic logic [31:0] memf(int g, logic [8:0] a);
    if (g == 0) return 32'(a) * 32'h1111;
    return 32'h5A00_0000 ^ (32'(a) * 32'h0001_0003);
  endfunction

  logic              clk;
  logic [2:0]        rst, rdy;
  logic [31:0]       rd;
  logic              rdv;
  logic              rnd_b;
  logic [2:0][31:0]  md;
  wire  [2:0]        mre, frz, dv, dl, dt, halted, done;
  wire  [2:0][8:0]   ma, da;
  wire  [2:0][31:0]  dd, cc;

  int    checks, errors;
  beat_t exp_q[3][$];
  beat_t act;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CW = (g == 2) ? 4 : 32;
    wire [CW-1:0] ccl;
    assign cc[g] = 32'(ccl);

    halt_dump_ctrl #(
      .DATA_W(32), .ADDR_W(9), .DEPTH(dep_of(g)), .HALT_WORD(HW),
      .DRAIN_CYCLES(drn_of(g)), .CNT_W(CW)
    ) u_dut (
      .CLK(clk), .RESET(rst[g]), .RD(rd), .RD_VALID(rdv),
      .MEM_RE(mre[g]), .MEM_ADDR(ma[g]), .MEM_DATA(md[g]),
      .CPU_FREEZE(frz[g]), .DUMP_VALID(dv[g]), .DUMP_READY(rdy[g]),
      .DUMP_DATA(dd[g]), .DUMP_ADDR(da[g]), .DUMP_LAST(dl[g]),
      .DUMP_TRAILER(dt[g]), .CYCLE_COUNT(ccl), .HALTED(halted[g]),
      .DONE(done[g])
    );
  end

  // Memory model: data only valid the cycle after a read, garbage otherwise.
  always @(posedge clk)
    for (int g = 0; g < 3; g++)
      md[g] <= mre[g] ? memf(g, ma[g]) : 32'hDEAD_BEEF;

  // Random backpressure for the big dump.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_b) rdy[1] = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: every presented beat must match the queue head; pop on handshake.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (!rst[g] && dv[g]) begin
        act = {da[g], dd[g], dl[g], dt[g]};
        checks++;
        if (exp_q[g].size() == 0) begin
          errors++;
          $display("FAIL beat_extra dut%0d: got addr=%0d data=%h last=%b trl=%b, required no beat",
                   g, act.addr, act.data, act.last, act.trl);
        end else begin
          if (act !== exp_q[g][0]) begin
            errors++;
            $display("FAIL beat dut%0d: got addr=%0d data=%h last=%b trl=%b, required addr=%0d data=%h last=%b trl=%b",
                     g, act.addr, act.data, act.last, act.trl, exp_q[g][0].addr,
                     exp_q[g][0].data, exp_q[g][0].last, exp_q[g][0].trl);
          end
          if (rdy[g]) void'(exp_q[g].pop_front());
        end
      end
    end
  end

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, a, e);
    end
  endtask

  task automatic chk_zero(int i, string nm);
    chk({nm, "_ctrl"}, 64'({mre[i], frz[i], dv[i], dl[i], dt[i], halted[i], done[i], ma[i], da[i]}), 64'd0);
    chk({nm, "_data"}, {dd[i], cc[i]}, 64'd0);
  endtask

  // Release reset, run n cycles, then issue the halt word and measure the
  // latency to the first memory read.
  task automatic run_halt(int i, int n, bit pre_hw, logic [31:0] exp_pre, logic [31:0] exp_trl);
    int   k;
    logic prevf;
    @(negedge clk);
    rst[i] = 1'b0;
    rd     = pre_hw ? HW : 32'd0;
    rdv    = !pre_hw;
    repeat (n) @(negedge clk);
    chk($sformatf("d%0d_count_pre", i), 64'(cc[i]), 64'(exp_pre));
    chk($sformatf("d%0d_halted_pre", i), 64'(halted[i]), 64'd0);
    for (int a = 0; a < dep_of(i); a++)
      exp_q[i].push_back({9'(a), memf(i, 9'(a)), 1'b0, 1'b0});
    exp_q[i].push_back({9'd0, exp_trl, 1'b1, 1'b1});
    rd    = HW;
    rdv   = 1'b1;
    prevf = frz[i];
    k     = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        chk($sformatf("d%0d_halted_post", i), 64'(halted[i]), 64'd1);
        rdv = 1'b0;
        rd  = 32'd0;
      end
      if (mre[i]) break;
      prevf = frz[i];
    end
    chk($sformatf("d%0d_re_latency", i), 64'(k), 64'(drn_of(i) + 1));
    chk($sformatf("d%0d_freeze_rise", i), 64'({prevf, frz[i]}), 64'b01);
    chk($sformatf("d%0d_first_addr", i), 64'(ma[i]), 64'd0);
  endtask

  task automatic wait_done(int i, int budget, logic [31:0] exp_cnt);
    int k = 0;
    while (!done[i] && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("d%0d_done", i), 64'(done[i]), 64'd1);
    chk($sformatf("d%0d_finish_outs", i), 64'({dv[i], frz[i], mre[i]}), 64'b010);
    chk($sformatf("d%0d_count_final", i), 64'(cc[i]), 64'(exp_cnt));
    chk($sformatf("d%0d_beats_left", i), 64'(exp_q[i].size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    checks = 0;
    errors = 0;
    rst    = 3'b111;
    rdy    = 3'b111;
    rd     = 32'd0;
    rdv    = 1'b0;
    rnd_b  = 1'b0;
    #12;
    for (int i = 0; i < 3; i++) chk_zero(i, $sformatf("d%0d_reset", i));

    // DEPTH=4, drain 3, 10 idle cycles -> trailer count 11.
    run_halt(0, 10, 1'b0, 32'd10, 32'd11);
    wait_done(0, 200, 32'd11);
    repeat (3) @(negedge clk);
    chk("d0_terminal", 64'({done[0], dv[0], frz[0]}), 64'b101);

    // DEPTH=512: stall at address 7, then reset in SEND.
    run_halt(1, 3, 1'b0, 32'd3, 32'd4);
    k = 0;
    while (!(mre[1] && ma[1] == 9'd7) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("d1_reach_addr7", 64'({mre[1], ma[1]}), 64'({1'b1, 9'd7}));
    rdy[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("d1_send_addr7", 64'({dv[1], da[1]}), 64'({1'b1, 9'd7}));
    repeat (2) @(negedge clk);
    chk("d1_stall_hold", 64'({dv[1], da[1], dd[1]}), 64'({1'b1, 9'd7, memf(1, 9'd7)}));
    #1 rst[1] = 1'b1;
    #1 chk_zero(1, "d1_midreset");
    exp_q[1].delete();
    rnd_b = 1'b1;
    repeat (3) @(negedge clk);
    run_halt(1, 5, 1'b0, 32'd5, 32'd6);
    wait_done(1, 8000, 32'd6);
    rnd_b = 1'b0;

    // CNT_W=4, no drain: invalid halt word ignored, counter saturates.
    run_halt(2, 20, 1'b1, 32'd15, 32'd15);
    wait_done(2, 100, 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/halt_dump_ctrl.md
HALT_DUMP_CTRL -- requirements
Module: halt_dump_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word / observed-instruction width.
REQ-002 SHALL have parameter ADDR_W, default 9, memory address width.
REQ-003 SHALL have parameter DEPTH, default 512, number of words dumped, 1..2^ADDR_W.
REQ-004 SHALL have parameter HALT_WORD, default {DATA_W{1'b1}}, sentinel that ends the run.
REQ-005 SHALL have parameter DRAIN_CYCLES, default 3, pipeline-drain wait after halt, 0..255.
REQ-006 SHALL have parameter CNT_W, default 32, cycle counter width.
REQ-007 SHALL have port CLK, input, 1, sole clock, rising edge.
REQ-008 SHALL have port RESET, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port RD, input, DATA_W, instruction word observed from the CPU fetch stage.
REQ-010 SHALL have port RD_VALID, input, 1, RD is meaningful this cycle.
REQ-011 SHALL have port MEM_RE, output, 1, data-memory read enable.
REQ-012 SHALL have port MEM_ADDR, output, ADDR_W, data-memory read address.
REQ-013 SHALL have port MEM_DATA, input, DATA_W, read data, valid exactly 1 cycle after MEM_RE.
REQ-014 SHALL have port CPU_FREEZE, output, 1, stalls the CPU once drain completes.
REQ-015 SHALL have ports DUMP_VALID out 1, DUMP_READY in 1, DUMP_DATA out DATA_W, DUMP_ADDR out ADDR_W, DUMP_LAST out 1, DUMP_TRAILER out 1: dump stream.
REQ-016 SHALL have ports CYCLE_COUNT out CNT_W (run-length count), HALTED out 1, DONE out 1.

Function
REQ-017 SHALL implement FSM states RUN, DRAIN, READ, CAPTURE, SEND, TRAILER, FINISH.
REQ-018 In RUN, CYCLE_COUNT SHALL increment every cycle, saturating at 2^CNT_W-1.
REQ-019 RUN->DRAIN SHALL occur when RD_VALID=1 and RD==HALT_WORD; the detection cycle is counted, and CYCLE_COUNT freezes from the next cycle onward.
REQ-020 HALTED SHALL rise the cycle after detection and stay 1 until reset; RD/RD_VALID SHALL be ignored outside RUN.
REQ-021 DRAIN SHALL last exactly DRAIN_CYCLES cycles (0: direct RUN->READ), then enter READ with pointer=0; CPU_FREEZE SHALL be 1 in READ and all later states.
REQ-022 READ SHALL assert MEM_RE=1 with MEM_ADDR=pointer for one cycle, then go to CAPTURE; MEM_RE SHALL be 0 in all other states.
REQ-023 CAPTURE SHALL register MEM_DATA into DUMP_DATA and pointer into DUMP_ADDR, then go to SEND.
REQ-024 SEND SHALL hold DUMP_VALID=1 with DUMP_DATA/DUMP_ADDR stable until DUMP_READY=1.
REQ-025 On a SEND handshake: pointer==DEPTH-1 -> TRAILER; otherwise pointer+1 -> READ.
REQ-026 TRAILER SHALL present DUMP_VALID=1, DUMP_TRAILER=1, DUMP_LAST=1, DUMP_ADDR=0, DUMP_DATA=CYCLE_COUNT zero-extended or truncated to DATA_W; on handshake -> FINISH.
REQ-027 DUMP_LAST and DUMP_TRAILER SHALL be 0 on every memory beat.
REQ-028 FINISH SHALL be terminal until reset: DONE=1, DUMP_VALID=0, CPU_FREEZE=1.
REQ-029 DUMP_READY held high SHALL yield one memory beat every 3 cycles; DUMP_READY low SHALL stall indefinitely without loss or duplication.

Reset
REQ-030 RESET SHALL asynchronously force state RUN, CYCLE_COUNT=0, pointer=0, and HALTED, DONE, CPU_FREEZE, MEM_RE, DUMP_VALID, DUMP_LAST, DUMP_TRAILER=0; DUMP_DATA=0, DUMP_ADDR=0, MEM_ADDR=0.
REQ-031 RESET asserted mid-dump SHALL abandon the dump; after release, counting restarts from 0 in RUN on the first CLK edge.

Structure
REQ-032 State encoding and default HALT_WORD/DRAIN_CYCLES constants SHALL live in shared package cpu_dbg_pkg.
REQ-033 The drain/cycle counting SHALL be a sub-module dbg_cycle_counter (saturating, enable, freeze); the rest stays flat.

Verification
REQ-034 Reset, 10 cycles of RD=0, then RD=32'hFFFFFFFF valid -> HALTED=1 next cycle, trailer DUMP_DATA=11.
REQ-035 DRAIN_CYCLES=3 -> first MEM_RE exactly 4 cycles after detection, CPU_FREEZE rising in the same cycle.
REQ-036 DEPTH=4, memory[i]=i*16'h1111, DUMP_READY=1 -> beats (0,0000),(1,1111),(2,2222),(3,3333), then trailer with LAST=1; DONE=1.
REQ-037 DUMP_READY toggled randomly, DEPTH=512 -> exactly 512 memory beats with in-order addresses and no duplicates, then 1 trailer.
REQ-038 RD=HALT_WORD with RD_VALID=0 -> no halt; CNT_W=4, 20 cycles -> CYCLE_COUNT saturates at 15.
REQ-039 RESET pulsed during SEND at address 7 -> all outputs 0 immediately (asynchronously); a subsequent halt produces a full dump from address 0.
